// File: rtl/analog_axis_ctrl.sv
// Player-1 analog axis / fire-button source controller: picks between the
// hps_io analog stick and an accumulated, self-recentering PS/2 mouse position.
module analog_axis_ctrl #(
  parameter int unsigned STEP_LIMIT   = 10,
  parameter int unsigned IDLE_TIMEOUT = 28000000,
  parameter int unsigned RECENTER_DIV = 65536
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [24:0] ps2_mouse,
  input  logic [15:0] joya,
  input  logic [15:0] joy_in,
  input  logic        cpu_halt,
  output logic [7:0]  ax,
  output logic [7:0]  ay,
  output logic [15:0] joy_out,
  output logic        mouse_active
);

  localparam int unsigned IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam int unsigned DIV_W  = $clog2(RECENTER_DIV + 1);

  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TIMEOUT - 1);
  localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(RECENTER_DIV - 1);

  localparam logic signed [8:0] STEP_POS = 9'(STEP_LIMIT);
  localparam logic signed [8:0] STEP_NEG = -STEP_POS;

  localparam logic [1:0] ST_JOY      = 2'd0;
  localparam logic [1:0] ST_MOUSE    = 2'd1;
  localparam logic [1:0] ST_RECENTER = 2'd2;

  logic [1:0]         state_q, state_d;
  logic signed [7:0]  mx_q, mx_d, my_q, my_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               centered_q, centered_d;
  logic               strobe_hist_q, hist_vld_q;

  logic               strobe_c, override_c, active_c;
  logic signed [8:0]  dx_c, dy_c;

  // Clamp a raw packet delta, add it to the position, saturate to 8 bits.
  function automatic logic signed [7:0] apply_delta(input logic signed [7:0] pos,
                                                    input logic signed [8:0] d);
    logic signed [8:0] c;
    logic signed [9:0] s;
    c = d;
    if (d > STEP_POS)      c = STEP_POS;
    else if (d < STEP_NEG) c = STEP_NEG;
    s = {{2{pos[7]}}, pos} + {c[8], c};
    if (s > 10'sd127)       apply_delta = 8'sd127;
    else if (s < -10'sd128) apply_delta = -8'sd128;
    else                    apply_delta = s[7:0];
  endfunction

  function automatic logic signed [7:0] toward_zero(input logic signed [7:0] pos);
    if (pos > 8'sd0)      toward_zero = pos - 8'sd1;
    else if (pos < 8'sd0) toward_zero = pos + 8'sd1;
    else                  toward_zero = pos;
  endfunction

  // History only becomes valid after the first post-reset clock, so a
  // pre-existing strobe level is never mistaken for a packet.
  assign strobe_c   = hist_vld_q && (ps2_mouse[24] != strobe_hist_q);
  assign override_c = (joya != 16'd0) || cpu_halt;
  assign dx_c       = $signed({ps2_mouse[4], ps2_mouse[15:8]});
  assign dy_c       = $signed({ps2_mouse[5], ps2_mouse[23:16]});

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q       <= ST_JOY;
      mx_q          <= '0;
      my_q          <= '0;
      idle_q        <= '0;
      div_q         <= '0;
      centered_q    <= 1'b0;
      strobe_hist_q <= 1'b0;
      hist_vld_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      mx_q          <= mx_d;
      my_q          <= my_d;
      idle_q        <= idle_d;
      div_q         <= div_d;
      centered_q    <= centered_d;
      strobe_hist_q <= ps2_mouse[24];
      hist_vld_q    <= 1'b1;
    end
  end

  // Next-state: override beats everything, then strobes, then idle/recenter timing.
  always_comb begin
    state_d    = state_q;
    mx_d       = mx_q;
    my_d       = my_q;
    idle_d     = idle_q;
    div_d      = div_q;
    centered_d = centered_q;

    if (override_c) begin
      state_d    = ST_JOY;
      mx_d       = '0;
      my_d       = '0;
      idle_d     = '0;
      div_d      = '0;
      centered_d = 1'b0;
    end else begin
      case (state_q)
        ST_JOY: begin
          if (strobe_c) begin
            state_d    = ST_MOUSE;
            mx_d       = apply_delta(mx_q, dx_c);
            my_d       = apply_delta(my_q, dy_c);
            idle_d     = '0;
            centered_d = 1'b0;
          end
        end
        ST_MOUSE: begin
          if (strobe_c) begin
            mx_d       = apply_delta(mx_q, dx_c);
            my_d       = apply_delta(my_q, dy_c);
            idle_d     = '0;
            centered_d = 1'b0;
          end else if (idle_q == IDLE_MAX) begin
            // Already recentered since the last packet: just hold the count.
            if (!centered_q) begin
              state_d = ST_RECENTER;
              div_d   = '0;
            end
          end else begin
            idle_d = idle_q + IDLE_W'(1);
          end
        end
        ST_RECENTER: begin
          if (strobe_c) begin
            state_d    = ST_MOUSE;
            mx_d       = apply_delta(mx_q, dx_c);
            my_d       = apply_delta(my_q, dy_c);
            idle_d     = '0;
            centered_d = 1'b0;
          end else if (mx_q == 8'sd0 && my_q == 8'sd0) begin
            state_d    = ST_MOUSE;
            idle_d     = '0;
            centered_d = 1'b1;
          end else if (div_q == DIV_MAX) begin
            div_d = '0;
            mx_d  = toward_zero(mx_q);
            my_d  = toward_zero(my_q);
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
        default: begin
          state_d = ST_JOY;
        end
      endcase
    end
  end

  assign active_c = (state_d != ST_JOY);

  // Output registers follow the next state so they appear one clock after the inputs.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ax           <= '0;
      ay           <= '0;
      joy_out      <= '0;
      mouse_active <= 1'b0;
    end else begin
      mouse_active <= active_c;
      ax           <= active_c ? mx_d : joya[7:0];
      ay           <= active_c ? my_d : joya[15:8];
      joy_out      <= active_c ? {joy_in[15:6], ps2_mouse[1:0], joy_in[3:0]} : joy_in;
    end
  end

endmodule

// File: tb/tb_analog_axis_ctrl.sv
// Randomized scoreboard bench for analog_axis_ctrl against an arithmetic
// reference model of the source-selection / mouse-accumulation rules.
module tb_analog_axis_ctrl;

  localparam int SL = 10;
  localparam int IT = 16;
  localparam int RD = 4;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic [24:0] ps2_mouse = '0;
  logic [15:0] joya = '0;
  logic [15:0] joy_in = '0;
  logic        cpu_halt = 1'b0;
  logic [7:0]  ax, ay;
  logic [15:0] joy_out;
  logic        mouse_active;

  analog_axis_ctrl #(.STEP_LIMIT(SL), .IDLE_TIMEOUT(IT), .RECENTER_DIV(RD)) dut (
    .clk_sys(clk_sys), .reset(reset), .ps2_mouse(ps2_mouse), .joya(joya),
    .joy_in(joy_in), .cpu_halt(cpu_halt), .ax(ax), .ay(ay),
    .joy_out(joy_out), .mouse_active(mouse_active)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [7:0]  ax;
    logic [7:0]  ay;
    logic [15:0] jo;
    logic        act;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: mode 0 = analog stick, 1 = mouse, 2 = recentering.
  int   m_mode, m_x, m_y, m_idle, m_div;
  bit   m_centered, m_hist, m_hist_ok;
  logic tog = 1'b0;

  function automatic int clamp_sat(input int pos, input int d);
    int c, v;
    c = (d > SL) ? SL : ((d < -SL) ? -SL : d);
    v = pos + c;
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    return v;
  endfunction

  function automatic int sgn(input int v);
    return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_x = 0; m_y = 0; m_idle = 0; m_div = 0;
    m_centered = 0; m_hist = 0; m_hist_ok = 0;
  endtask

  task automatic model_step(output exp_t e);
    bit strobe;
    int dx, dy;
    logic [7:0] tx, ty;
    strobe    = m_hist_ok && (ps2_mouse[24] != m_hist);
    m_hist    = ps2_mouse[24];
    m_hist_ok = 1;
    dx = int'(ps2_mouse[15:8]) - (ps2_mouse[4] ? 256 : 0);
    dy = int'(ps2_mouse[23:16]) - (ps2_mouse[5] ? 256 : 0);
    if (joya != 0 || cpu_halt) begin
      m_mode = 0; m_x = 0; m_y = 0; m_idle = 0; m_div = 0; m_centered = 0;
    end else if (strobe) begin
      m_mode = 1; m_x = clamp_sat(m_x, dx); m_y = clamp_sat(m_y, dy);
      m_idle = 0; m_centered = 0;
    end else if (m_mode == 1) begin
      if (m_idle < IT - 1) m_idle++;
      else if (!m_centered) begin m_mode = 2; m_div = 0; end
    end else if (m_mode == 2) begin
      if (m_x == 0 && m_y == 0) begin
        m_mode = 1; m_idle = 0; m_centered = 1;
      end else if (m_div == RD - 1) begin
        m_div = 0; m_x -= sgn(m_x); m_y -= sgn(m_y);
      end else m_div++;
    end
    tx = m_x[7:0];
    ty = m_y[7:0];
    e.act = (m_mode != 0);
    e.ax  = e.act ? tx : joya[7:0];
    e.ay  = e.act ? ty : joya[15:8];
    e.jo  = e.act ? {joy_in[15:6], ps2_mouse[1:0], joy_in[3:0]} : joy_in;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // One clock of stimulus; the expected output of that edge goes to the scoreboard.
  task automatic cycle(input bit strobe, input logic [7:0] dxb, input bit dxs,
                       input logic [7:0] dyb, input bit dys, input logic [1:0] btn,
                       input logic [15:0] ja, input logic [15:0] jin, input bit halt);
    exp_t e;
    @(negedge clk_sys);
    if (strobe) tog = ~tog;
    ps2_mouse = {tog, dyb, dxb, 2'b00, dys, dxs, 2'b00, btn};
    joya = ja; joy_in = jin; cpu_halt = halt;
    @(posedge clk_sys);
    if (reset) begin model_reset(); e = '0; end
    else model_step(e);
    exp_q.push_back(e);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(0, 8'h00, 0, 8'h00, 0, 2'b00, 16'h0, 16'h1234, 0);
  endtask

  task automatic rand_cycle(input int strobe_pct, input int ovr_pct);
    bit s, h;
    logic [15:0] ja;
    s  = ($urandom_range(99) < strobe_pct);
    ja = ($urandom_range(99) < ovr_pct) ? 16'($urandom) : 16'h0;
    h  = ($urandom_range(99) < ovr_pct / 2);
    if ($urandom_range(3) == 0)
      cycle(s, 8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom),
            2'($urandom), ja, 16'($urandom), h);
    else
      cycle(s, 8'($urandom_range(12)), 1'($urandom), 8'($urandom_range(12)) , 1'($urandom),
            2'($urandom), ja, 16'($urandom), h);
  endtask

  // Monitor: every clock the DUT presents a new output word.
  always @(posedge clk_sys) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e, g;
      e = exp_q.pop_front();
      g = {ax, ay, joy_out, mouse_active};
      check("outputs{ax,ay,joy_out,active}", 64'(g), 64'(e));
    end
  end

  initial begin
    model_reset();
    joya = 16'h40C0;
    #1;
    check("reset_ax", 64'(ax), 64'h0);
    check("reset_active", 64'(mouse_active), 64'h0);
    repeat (2) cycle(0, 8'h00, 0, 8'h00, 0, 2'b00, 16'h40C0, 16'h0, 0);
    @(negedge clk_sys); reset = 1'b0;
    // Stick passthrough.
    repeat (3) cycle(0, 8'h00, 0, 8'h00, 0, 2'b00, 16'h40C0, 16'hABCD, 0);
    #2;
    check("stick_ax", 64'(ax), 64'hC0);
    check("stick_ay", 64'(ay), 64'h40);
    // First packet dX=+5, dY=-3.
    cycle(1, 8'h05, 0, 8'hFD, 1, 2'b10, 16'h0, 16'hFFFF, 0);
    #2;
    check("pkt_ax", 64'(ax), 64'h05);
    check("pkt_ay", 64'(ay), 64'hFD);
    check("pkt_buttons", 64'(joy_out), 64'hFFEF);
    // Saturation then a clamped negative step.
    for (int i = 0; i < 20; i++) cycle(1, 8'd100, 0, 8'h00, 0, 2'b01, 16'h0, 16'h0, 0);
    #2 check("sat_ax", 64'(ax), 64'h7F);
    cycle(1, 8'h9C, 1, 8'h00, 0, 2'b01, 16'h0, 16'h0, 0);
    #2 check("unsat_ax", 64'(ax), 64'h75);
    // Set mx=3,my=-2 then idle through recentering.
    cycle(0, 8'h00, 0, 8'h00, 0, 2'b00, 16'h0001, 16'h0, 0);
    cycle(1, 8'h03, 0, 8'hFE, 1, 2'b00, 16'h0, 16'h0, 0);
    idle_cycles(60);
    #2 check("recentered_ax", 64'(ax), 64'h0);
    check("recentered_active", 64'(mouse_active), 64'h1);
    // Strobe coinciding with stick activity is discarded.
    cycle(1, 8'h07, 0, 8'h07, 0, 2'b00, 16'h0001, 16'h0, 0);
    cycle(0, 8'h00, 0, 8'h00, 0, 2'b00, 16'h0001, 16'h0, 0);
    #2 check("override_ax", 64'(ax), 64'h01);
    // cpu_halt while mouse at 50.
    for (int i = 0; i < 5; i++) cycle(1, 8'd10, 0, 8'h00, 0, 2'b00, 16'h0, 16'h0, 0);
    cycle(0, 8'h00, 0, 8'h00, 0, 2'b00, 16'h0, 16'h0, 1);
    #2 check("halt_active", 64'(mouse_active), 64'h0);
    // Randomized traffic with varying packet density.
    for (int blk = 0; blk < 20; blk++) begin
      int sp, op;
      sp = (blk % 3 == 0) ? 3 : ((blk % 3 == 1) ? 30 : 70);
      op = (blk % 4 == 0) ? 8 : 1;
      for (int i = 0; i < 150; i++) rand_cycle(sp, op);
    end
    // Async reset mid-recenter.
    cycle(1, 8'd9, 0, 8'd9, 0, 2'b11, 16'h0, 16'hFFFF, 0);
    idle_cycles(IT + 2);
    @(negedge clk_sys);
    #2 reset = 1'b1;
    #1;
    check("async_rst_ax", 64'(ax), 64'h0);
    check("async_rst_ay", 64'(ay), 64'h0);
    check("async_rst_joy", 64'(joy_out), 64'h0);
    check("async_rst_active", 64'(mouse_active), 64'h0);
    model_reset();
    cycle(1, 8'd4, 0, 8'd4, 0, 2'b11, 16'h0, 16'hFFFF, 0);
    @(negedge clk_sys); reset = 1'b0;
    // Level held high across reset must not count as a packet.
    idle_cycles(3);
    #2 check("post_rst_no_strobe", 64'(mouse_active), 64'h0);
    for (int i = 0; i < 500; i++) rand_cycle(25, 2);
    repeat (3) @(posedge clk_sys);
    #2;
    check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
